// File: rtl/accel_spi_pkg.sv
// Shared constants for the ADXL362 SPI reader: opcodes, register map, FSM encoding
// and the small byte helpers used when building frames and post-processing samples.
package accel_spi_pkg;

  localparam logic [7:0] CMD_WR        = 8'h0A;
  localparam logic [7:0] CMD_RD        = 8'h0B;
  localparam logic [7:0] REG_XDATA     = 8'h08;
  localparam logic [7:0] REG_POWER_CTL = 8'h2D;
  localparam logic [7:0] PWR_MEASURE   = 8'h02;

  typedef enum logic [2:0] {
    ST_WAIT_PWR,
    ST_INIT_WR,
    ST_GAP,
    ST_IDLE,
    ST_RD,
    ST_UPDATE
  } state_t;

  // Byte idx of the configuration write (is_rd=0) or the XDATA/YDATA burst read.
  function automatic logic [7:0] frame_byte(input logic is_rd, input logic [1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    if (is_rd) begin
      case (idx)
        2'd0:    b = CMD_RD;
        2'd1:    b = REG_XDATA;
        default: b = 8'h00;
      endcase
    end else begin
      case (idx)
        2'd0:    b = CMD_WR;
        2'd1:    b = REG_POWER_CTL;
        2'd2:    b = PWR_MEASURE;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  // Two's-complement negate that clamps -128 to +127 instead of wrapping.
  function automatic logic [7:0] neg_sat(input logic [7:0] b);
    return (b == 8'h80) ? 8'h7F : (8'h00 - b);
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Full-duplex 8-bit SPI mode-0 shifter. A load accepted on the final SCLK fall chains
// the next byte with no idle half period, so multi-byte frames keep a continuous clock.
module spi_byte_shifter #(
  parameter int unsigned HALF = 50
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       ready,
  output logic [7:0] rx_byte,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  logic        busy;
  logic [31:0] cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_sr;
  logic [7:0]  rx_sr;
  logic        miso_s;
  logic        half_end;
  logic        last_fall;

  // Two flops need at least HALF>=4 cycles between MISO change and the sampling edge.
  generate
    if (HALF >= 4) begin : g_sync
      logic [1:0] sync;
      always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) sync <= 2'b00;
        else        sync <= {sync[0], miso};
      end
      assign miso_s = sync[1];
    end else begin : g_direct
      assign miso_s = miso;
    end
  endgenerate

  assign half_end  = busy && (cnt == HALF - 32'd1);
  assign last_fall = half_end && sclk && (bit_cnt == 3'd7);
  assign ready     = !busy || last_fall;
  assign mosi      = tx_sr[7];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      cnt     <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_byte <= '0;
      done    <= 1'b0;
      sclk    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && ready) begin
        busy    <= 1'b1;
        cnt     <= '0;
        sclk    <= 1'b0;
        bit_cnt <= '0;
        tx_sr   <= tx_byte;
        if (last_fall) begin
          done    <= 1'b1;
          rx_byte <= rx_sr;
        end
      end else if (half_end) begin
        cnt  <= '0;
        sclk <= !sclk;
        if (!sclk) begin
          rx_sr <= {rx_sr[6:0], miso_s};
        end else if (bit_cnt == 3'd7) begin
          busy    <= 1'b0;
          done    <= 1'b1;
          rx_byte <= rx_sr;
          tx_sr   <= '0;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
          tx_sr   <= {tx_sr[6:0], 1'b0};
        end
      end else if (busy) begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/accel_spi_reader.sv
// ADXL362 SPI master: one POWER_CTL write after power-up, then periodic X/Y MSB reads.
// Define ACCEL_AVG_EN to add a 4-sample box filter (one extra cycle of latency).
module accel_spi_reader
  import accel_spi_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
  parameter int unsigned SCLK_HZ        = 1_000_000,
  parameter int unsigned SAMPLE_HZ      = 100,
  parameter int unsigned STARTUP_CYCLES = 500_000,
  parameter int unsigned CS_GAP_CYCLES  = 100,
  parameter bit          INVERT_X       = 1'b0,
  parameter bit          INVERT_Y       = 1'b0,
  parameter bit          SWAP_XY        = 1'b0
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       enable,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n,
  output logic [7:0] accel_x,
  output logic [7:0] accel_y,
  output logic       accel_valid,
  output logic       init_done
);

  localparam int unsigned HALF     = CLK_FREQ_HZ / (2 * SCLK_HZ);
  localparam int unsigned TICK_DIV = CLK_FREQ_HZ / SAMPLE_HZ;

  state_t      state;
  logic [31:0] timer;
  logic [31:0] tick_cnt;
  logic        tick;
  logic [2:0]  byte_idx;
  logic [2:0]  nbytes;
  logic [1:0]  done_cnt;
  logic        in_hold;
  logic [7:0]  x_raw, y_raw, x_new, y_new, x_proc, y_proc;
  logic        proc_valid;
  logic        sh_start, sh_ready, sh_done;
  logic [7:0]  sh_tx, sh_rx;

  spi_byte_shifter #(.HALF(HALF)) u_shifter (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .start   (sh_start),
    .tx_byte (sh_tx),
    .ready   (sh_ready),
    .rx_byte (sh_rx),
    .done    (sh_done),
    .sclk    (spi_sclk),
    .mosi    (spi_mosi),
    .miso    (spi_miso)
  );

  // Free-running once configured; a tick outside IDLE is simply lost.
  assign tick = init_done && (tick_cnt == TICK_DIV - 32'd1);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)                  tick_cnt <= '0;
    else if (!init_done || tick) tick_cnt <= '0;
    else                         tick_cnt <= tick_cnt + 32'd1;
  end

  assign nbytes = (state == ST_RD) ? 3'd4 : 3'd3;

  // The first byte loads on the same edge cs_n falls, so the shifter's first low
  // half period doubles as the cs setup time.
  // NOTE: defaulting every always_comb output first keeps the block free of latches.
  always_comb begin
    sh_start = 1'b0;
    sh_tx    = 8'h00;
    case (state)
      ST_WAIT_PWR: if (timer == STARTUP_CYCLES - 32'd1) begin
        sh_start = 1'b1;
        sh_tx    = CMD_WR;
      end
      ST_IDLE: if (tick && enable) begin
        sh_start = 1'b1;
        sh_tx    = CMD_RD;
      end
      ST_INIT_WR, ST_RD: if (!in_hold && sh_ready && (byte_idx < nbytes)) begin
        sh_start = 1'b1;
        sh_tx    = frame_byte(state == ST_RD, byte_idx[1:0]);
      end
      default: ;
    endcase
  end

  always_comb begin
    x_new = SWAP_XY ? y_raw : x_raw;
    y_new = SWAP_XY ? x_raw : y_raw;
    if (INVERT_X) x_new = neg_sat(x_new);
    if (INVERT_Y) y_new = neg_sat(y_new);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_WAIT_PWR;
      timer      <= '0;
      spi_cs_n   <= 1'b1;
      byte_idx   <= '0;
      done_cnt   <= '0;
      in_hold    <= 1'b0;
      init_done  <= 1'b0;
      x_raw      <= '0;
      y_raw      <= '0;
      x_proc     <= '0;
      y_proc     <= '0;
      proc_valid <= 1'b0;
    end else begin
      proc_valid <= 1'b0;
      case (state)
        ST_WAIT_PWR: begin
          if (sh_start) begin
            state    <= ST_INIT_WR;
            spi_cs_n <= 1'b0;
            byte_idx <= 3'd1;
            done_cnt <= '0;
            timer    <= '0;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        ST_INIT_WR, ST_RD: begin
          if (sh_start) byte_idx <= byte_idx + 3'd1;
          if (in_hold) begin
            // timer was primed to 1 on the edge after the last SCLK fall
            if (timer >= HALF - 32'd1) begin
              spi_cs_n <= 1'b1;
              in_hold  <= 1'b0;
              timer    <= '0;
              if (state == ST_RD) begin
                state <= ST_UPDATE;
              end else begin
                init_done <= 1'b1;
                state     <= ST_GAP;
              end
            end else begin
              timer <= timer + 32'd1;
            end
          end else if (sh_done) begin
            if (state == ST_RD && done_cnt == 2'd2) x_raw <= sh_rx;
            if (state == ST_RD && done_cnt == 2'd3) y_raw <= sh_rx;
            if ({1'b0, done_cnt} == nbytes - 3'd1) begin
              in_hold <= 1'b1;
              timer   <= 32'd1;
            end else begin
              done_cnt <= done_cnt + 2'd1;
            end
          end
        end
        ST_GAP: begin
          if (timer >= CS_GAP_CYCLES - 32'd1) begin
            timer <= '0;
            state <= ST_IDLE;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        ST_IDLE: begin
          if (sh_start) begin
            state    <= ST_RD;
            spi_cs_n <= 1'b0;
            byte_idx <= 3'd1;
            done_cnt <= '0;
          end
        end
        ST_UPDATE: begin
          x_proc     <= x_new;
          y_proc     <= y_new;
          proc_valid <= 1'b1;
          timer      <= '0;
          state      <= ST_GAP;
        end
        default: state <= ST_WAIT_PWR;
      endcase
    end
  end

`ifdef ACCEL_AVG_EN
  logic [7:0] sample  [2];
  logic [7:0] hist    [2][4];
  logic [9:0] sum     [2];
  logic [9:0] sum_nxt [2];
  logic [7:0] avg_q   [2];
  logic       avg_valid;

  assign sample[0] = x_proc;
  assign sample[1] = y_proc;

  // Running sum: add the newest sample, drop the one falling out of the window.
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      sum_nxt[a] = sum[a] + {{2{sample[a][7]}}, sample[a]}
                          - {{2{hist[a][3][7]}}, hist[a][3]};
    end
  end

  // NOTE: the history is explicitly reset so the first averages ramp up from zero.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      avg_valid <= 1'b0;
      for (int a = 0; a < 2; a++) begin
        sum[a]   <= '0;
        avg_q[a] <= '0;
        for (int k = 0; k < 4; k++) hist[a][k] <= '0;
      end
    end else begin
      avg_valid <= proc_valid;
      if (proc_valid) begin
        for (int a = 0; a < 2; a++) begin
          sum[a]     <= sum_nxt[a];
          avg_q[a]   <= sum_nxt[a][9:2];
          hist[a][0] <= sample[a];
          for (int k = 1; k < 4; k++) hist[a][k] <= hist[a][k-1];
        end
      end
    end
  end

  assign accel_x     = avg_q[0];
  assign accel_y     = avg_q[1];
  assign accel_valid = avg_valid;
`else
  assign accel_x     = x_proc;
  assign accel_y     = y_proc;
  assign accel_valid = proc_valid;
`endif

endmodule
